// File: rtl/raisin64_pkg.sv
// Shared definitions for the raisin64 front end: machine width, fetch FSM
// encodings and the prefetch buffer entry layout.
package raisin64_pkg;

    localparam int XLEN        = 64;
    localparam int INSTR_BYTES = 8;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {pc, instr} pairs between imem and decode.
// Flush takes priority over push/pop; the head reads as zero when empty.
module fetch_fifo
    import raisin64_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wr_data,
    output fetch_entry_t  rd_data,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately left without reset; only the pointers and
    // count need a known value, and the head output is gated while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, single outstanding imem
// request, prefetch buffering and redirect handling with response discard.
module fetch_unit
    import raisin64_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_addr_valid,
    input  logic [XLEN-1:0] imem_data,
    input  logic            imem_data_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]      state;
    logic [1:0]      state_d;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] held_addr;

    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_after;
    logic            room;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // A redirect flushes the buffer, so neither side of the FIFO may act on it.
    assign pop         = if_valid && if_ready && !redirect_valid;
    assign push        = (state == ST_REQ) && imem_data_valid && !redirect_valid;
    assign count_after = count + CW'(push) - CW'(pop);
    assign room        = count_after < CW'(DEPTH);

    // NOTE: every combinational output gets a default before the case so no
    // path through the block leaves a value unassigned (no latch).
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (redirect_valid || room) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid)
                    state_d = imem_data_valid ? ST_REQ : ST_DISCARD;
                else if (imem_data_valid)
                    state_d = room ? ST_REQ : ST_IDLE;
            end
            ST_DISCARD: begin
                if (imem_data_valid) state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            fetch_pc  <= RESET_PC;
            held_addr <= '0;
        end else begin
            state <= state_d;
            if (redirect_valid)
                fetch_pc <= align_pc(redirect_pc);
            else if (push)
                fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
            // The abandoned request must keep its address until imem answers it.
            if (redirect_valid && (state == ST_REQ) && !imem_data_valid)
                held_addr <= fetch_pc;
        end
    end

    always_comb begin
        imem_addr_valid = 1'b0;
        imem_addr       = '0;
        case (state)
            ST_REQ: begin
                imem_addr_valid = 1'b1;
                imem_addr       = fetch_pc;
            end
            ST_DISCARD: begin
                imem_addr_valid = 1'b1;
                imem_addr       = held_addr;
            end
            default: ;
        endcase
    end

    assign push_entry = '{pc: fetch_pc, instr: imem_data};

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (push_entry),
        .rd_data (head),
        .count   (count)
    );

    assign if_valid = (count != '0);
    assign if_pc    = head.pc;
    assign if_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: imem behavioural RAM, queue-based
// scoreboard of fetched words, directed scenarios plus a random soak.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic        imem_addr_valid;
    logic [63:0] imem_data;
    logic        imem_data_valid;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [63:0] if_instr;
    logic [63:0] if_pc;
    logic        if_ready;

    fetch_unit #(
        .DEPTH(DEPTH),
        .RESET_PC(64'h0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_addr_valid (imem_addr_valid),
        .imem_data       (imem_data),
        .imem_data_valid (imem_data_valid),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_ready        (if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] instr;
    } ent_t;

    // Reference model state: words expected at decode, next expected fetch
    // address, and a pending-discard marker for abandoned requests.
    ent_t        mq[$];
    logic [63:0] exp_pc;
    logic        pending;
    logic [63:0] disc_addr;
    logic        hold_req;
    logic [63:0] hold_addr;

    logic [63:0] acc_log[$];
    int          acc_cyc[$];
    logic [63:0] pop_log[$];
    int          pop_cyc[$];
    int          disc_cnt;
    int          cyc;

    int          n_checks;
    int          n_fail;

    function automatic logic [63:0] ram_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_1234, ~a[63:32]} + 64'h9E37_79B9_7F4A_7C15;
    endfunction

    function automatic logic [63:0] aligned(input logic [63:0] a);
        return {a[63:3], 3'b000};
    endfunction

    task automatic clear_logs();
        acc_log.delete();
        acc_cyc.delete();
        pop_log.delete();
        pop_cyc.delete();
        disc_cnt = 0;
        cyc      = 0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs against
    // the model, then advance the model to what the next edge must produce.
    task automatic cycle(input logic dv, input logic rdy, input logic rv, input logic [63:0] rpc);
        logic acc;
        logic pop;
        int   outstanding;
        imem_data_valid = dv;
        if_ready        = rdy;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        imem_data       = ram_word(imem_addr);
        #1;
        n_checks++;
        if (if_valid !== (mq.size() != 0)) begin
            $display("FAIL if_valid cyc=%0d got=%b exp=%b", cyc, if_valid, mq.size() != 0);
            n_fail++;
        end
        if (mq.size() != 0) begin
            n_checks++;
            if (if_pc !== mq[0].pc || if_instr !== mq[0].instr) begin
                $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                         cyc, if_pc, if_instr, mq[0].pc, mq[0].instr);
                n_fail++;
            end
        end
        if (imem_addr_valid === 1'b1) begin
            n_checks++;
            if (imem_addr[2:0] !== 3'b000) begin
                $display("FAIL addr_align cyc=%0d got=%h", cyc, imem_addr);
                n_fail++;
            end
        end
        if (hold_req) begin
            n_checks++;
            if (imem_addr_valid !== 1'b1 || imem_addr !== hold_addr) begin
                $display("FAIL addr_stable cyc=%0d got valid=%b addr=%h exp addr=%h",
                         cyc, imem_addr_valid, imem_addr, hold_addr);
                n_fail++;
            end
        end
        outstanding = (imem_addr_valid === 1'b1 && !pending) ? 1 : 0;
        n_checks++;
        if (mq.size() + outstanding > DEPTH) begin
            $display("FAIL occupancy cyc=%0d got=%0d exp<=%0d", cyc, mq.size() + outstanding, DEPTH);
            n_fail++;
        end

        acc = (imem_addr_valid === 1'b1) && dv;
        pop = (mq.size() != 0) && rdy && !rv;
        if (acc && !rv) begin
            n_checks++;
            if (pending) begin
                disc_cnt++;
                if (imem_addr !== disc_addr) begin
                    $display("FAIL discard_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, disc_addr);
                    n_fail++;
                end
            end else begin
                acc_log.push_back(imem_addr);
                acc_cyc.push_back(cyc);
                if (imem_addr !== exp_pc) begin
                    $display("FAIL fetch_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, exp_pc);
                    n_fail++;
                end
            end
        end
        hold_req  = (imem_addr_valid === 1'b1) && !acc;
        hold_addr = imem_addr;
        if (rv) begin
            if (acc) pending = 1'b0;
            else if (imem_addr_valid === 1'b1 && !pending) begin
                pending   = 1'b1;
                disc_addr = imem_addr;
            end
            mq.delete();
            exp_pc = aligned(rpc);
        end else begin
            if (pop) begin
                pop_log.push_back(mq[0].pc);
                pop_cyc.push_back(cyc);
                void'(mq.pop_front());
            end
            if (acc) begin
                if (pending) pending = 1'b0;
                else begin
                    mq.push_back('{exp_pc, ram_word(exp_pc)});
                    exp_pc = exp_pc + 64'd8;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        imem_data_valid = 1'b0;
        if_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_data       = '0;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (imem_addr !== 64'h0 || imem_addr_valid !== 1'b0 || if_valid !== 1'b0 ||
            if_instr !== 64'h0 || if_pc !== 64'h0) begin
            $display("FAIL reset_outputs got addr=%h av=%b iv=%b instr=%h pc=%h exp all zero",
                     imem_addr, imem_addr_valid, if_valid, if_instr, if_pc);
            n_fail++;
        end
        mq.delete();
        exp_pc   = 64'h0;
        pending  = 1'b0;
        hold_req = 1'b0;
        clear_logs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (imem_addr_valid !== 1'b0) begin
            $display("FAIL reset_idle got av=%b exp=0", imem_addr_valid);
            n_fail++;
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (acc_log.size() != 9 || pop_log.size() != 8) begin
            $display("FAIL stream_counts got acc=%0d pop=%0d exp acc=9 pop=8", acc_log.size(), pop_log.size());
            n_fail++;
        end
        for (int i = 0; i < acc_log.size(); i++) begin
            n_checks++;
            if (acc_log[i] !== 64'(8 * i) || acc_cyc[i] != i + 1) begin
                $display("FAIL stream_req[%0d] got addr=%h cyc=%0d exp addr=%h cyc=%0d",
                         i, acc_log[i], acc_cyc[i], 64'(8 * i), i + 1);
                n_fail++;
            end
        end
        for (int i = 0; i < pop_log.size(); i++) begin
            n_checks++;
            if (pop_log[i] !== 64'(8 * i) || pop_cyc[i] != i + 2) begin
                $display("FAIL stream_pop[%0d] got pc=%h cyc=%0d exp pc=%h cyc=%0d",
                         i, pop_log[i], pop_cyc[i], 64'(8 * i), i + 2);
                n_fail++;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if (acc_log.size() != DEPTH || imem_addr_valid !== 1'b0 || if_pc !== 64'h0) begin
            $display("FAIL bp_full got reqs=%0d av=%b pc=%h exp reqs=%0d av=0 pc=0",
                     acc_log.size(), imem_addr_valid, if_pc, DEPTH);
            n_fail++;
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (pop_log.size() < 4 || acc_log.size() < 4) begin
            $display("FAIL bp_resume got pops=%0d reqs=%0d exp >=4 each", pop_log.size(), acc_log.size());
            n_fail++;
        end
        for (int i = 0; i < pop_log.size(); i++) begin
            n_checks++;
            if (pop_log[i] !== 64'(8 * i)) begin
                $display("FAIL bp_pop[%0d] got=%h exp=%h", i, pop_log[i], 64'(8 * i));
                n_fail++;
            end
        end
    endtask

    task automatic test_latency();
        int   wcnt;
        logic dv;
        do_reset();
        wcnt = 0;
        for (int i = 0; i < 22; i++) begin
            if (imem_addr_valid === 1'b1) begin
                dv   = (wcnt == 3);
                wcnt = dv ? 0 : wcnt + 1;
            end else begin
                dv   = 1'b0;
                wcnt = 0;
            end
            cycle(dv, 1'b1, 1'b0, '0);
        end
        n_checks++;
        if (acc_log.size() < 4 || pop_log.size() < 3) begin
            $display("FAIL lat_counts got reqs=%0d pops=%0d exp >=4, >=3", acc_log.size(), pop_log.size());
            n_fail++;
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 4) begin
                $display("FAIL lat_spacing[%0d] got=%0d exp=4", i, acc_cyc[i] - acc_cyc[i-1]);
                n_fail++;
            end
        end
        for (int i = 0; i < 3 && i < pop_log.size(); i++) begin
            n_checks++;
            if (pop_log[i] !== 64'(8 * i)) begin
                $display("FAIL lat_pop[%0d] got=%h exp=%h", i, pop_log[i], 64'(8 * i));
                n_fail++;
            end
        end
    endtask

    task automatic test_redirect_inflight();
        bit found;
        int abase;
        int pbase;
        int dbase;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_addr_valid === 1'b1 && imem_addr === 64'h10) found = 1'b1;
            else cycle(1'b1, 1'b1, 1'b0, '0);
        end
        n_checks++;
        if (!found) begin
            $display("FAIL redir_wait got no request to 0x10 within 20 cycles exp one");
            n_fail++;
        end else begin
            abase = acc_log.size();
            pbase = pop_log.size();
            dbase = disc_cnt;
            cycle(1'b0, 1'b1, 1'b1, 64'h107);
            n_checks++;
            if (if_valid !== 1'b0 || imem_addr_valid !== 1'b1 || imem_addr !== 64'h10) begin
                $display("FAIL redir_hold got iv=%b av=%b addr=%h exp iv=0 av=1 addr=10",
                         if_valid, imem_addr_valid, imem_addr);
                n_fail++;
            end
            cycle(1'b0, 1'b1, 1'b0, '0);
            cycle(1'b1, 1'b1, 1'b0, '0);
            for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, '0);
            n_checks++;
            if (disc_cnt - dbase != 1 || acc_log.size() <= abase || pop_log.size() <= pbase) begin
                $display("FAIL redir_counts got disc=%0d reqs=%0d pops=%0d exp disc=1 and progress",
                         disc_cnt - dbase, acc_log.size() - abase, pop_log.size() - pbase);
                n_fail++;
            end else begin
                n_checks++;
                if (acc_log[abase] !== 64'h100 || pop_log[pbase] !== 64'h100) begin
                    $display("FAIL redir_target got req=%h pop=%h exp 100", acc_log[abase], pop_log[pbase]);
                    n_fail++;
                end
            end
        end
    endtask

    task automatic test_redirect_same_cycle();
        logic [63:0] rpc;
        int          pbase;
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        rpc   = {$urandom, $urandom};
        pbase = pop_log.size();
        n_checks++;
        if (if_valid !== 1'b1 || imem_addr_valid !== 1'b1) begin
            $display("FAIL same_pre got iv=%b av=%b exp 1 1", if_valid, imem_addr_valid);
            n_fail++;
        end
        cycle(1'b1, 1'b1, 1'b1, rpc);
        n_checks++;
        if (if_valid !== 1'b0 || imem_addr_valid !== 1'b1 || imem_addr !== aligned(rpc)) begin
            $display("FAIL same_post got iv=%b av=%b addr=%h exp iv=0 av=1 addr=%h",
                     if_valid, imem_addr_valid, imem_addr, aligned(rpc));
            n_fail++;
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (pop_log.size() <= pbase || pop_log[pbase] !== aligned(rpc)) begin
            $display("FAIL same_deliver got pops=%0d exp first pc=%h", pop_log.size() - pbase, aligned(rpc));
            n_fail++;
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        cycle(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (acc_log.size() < 2 || acc_log[0] !== 64'hFFFF_FFFF_FFFF_FFF8 || acc_log[1] !== 64'h0) begin
            $display("FAIL wrap got reqs=%0d exp FFFFFFFFFFFFFFF8 then 0", acc_log.size());
            n_fail++;
        end
        cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if (imem_addr_valid !== 1'b1) begin
            $display("FAIL midreq_pre got av=%b exp=1", imem_addr_valid);
            n_fail++;
        end
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (acc_log.size() < 1 || acc_log[0] !== 64'h0) begin
            $display("FAIL midreq_restart got reqs=%0d exp first addr 0", acc_log.size());
            n_fail++;
        end
    endtask

    task automatic test_random();
        logic        dv;
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            dv  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31))
                                              : {32'h0, $urandom};
            cycle(dv, rdy, rv, rpc);
        end
        n_checks++;
        if (pop_log.size() < 100) begin
            $display("FAIL random_progress got pops=%0d exp >=100", pop_log.size());
            n_fail++;
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        imem_data_valid = 1'b0;
        imem_data       = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        if_ready        = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_latency();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_wrap_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
